// File: rtl/song_sequencer.sv
// Song sequencer: walks note/duration entries of a song ROM, times each note in beats and drives the note player.
// Optional SONG_SEQ_LOOP_EN: end of song restarts the same song instead of advancing.
module song_sequencer #(
    parameter int SONG_W     = 2,
    parameter int NOTE_IDX_W = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         play_i,
    input  logic                         next_song_i,
    input  logic                         beat_i,
    output logic [SONG_W+NOTE_IDX_W-1:0] rom_addr_o,
    input  logic [15:0]                  rom_data_i,
    output logic [5:0]                   note_to_load_o,
    output logic                         play_enable_o,
    output logic                         note_load_o,
    output logic                         song_done_o,
    output logic [SONG_W-1:0]            song_o
);

    // state | meaning
    // FETCH | rom_addr presented, ROM word arrives next cycle
    // LOAD  | ROM word sampled: latch note or detect end marker
    // PLAY  | note sounding, counting beats down while play is high
    // END   | end of song: pulse song_done, move to next (or same) song
    typedef enum logic [1:0] {S_FETCH, S_LOAD, S_PLAY, S_END} state_e;

    state_e                state_q, state_d;
    logic [SONG_W-1:0]     song_q, song_d;
    logic [NOTE_IDX_W-1:0] idx_q, idx_d;
    logic [5:0]            note_q, note_d;
    logic [5:0]            cnt_q, cnt_d;
    logic                  pe_q, pe_d;
    logic                  note_load, song_done;
    logic [5:0]            rom_dur;
    logic                  beat_ok;

    assign rom_dur = rom_data_i[5:0];
    assign beat_ok = (state_q == S_PLAY) && play_i && beat_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_FETCH;
            song_q  <= '0;
            idx_q   <= '0;
            note_q  <= '0;
            cnt_q   <= '0;
            pe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            song_q  <= song_d;
            idx_q   <= idx_d;
            note_q  <= note_d;
            cnt_q   <= cnt_d;
            pe_q    <= pe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (next_song_i) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: state_d = S_LOAD;
                S_LOAD:  state_d = (rom_dur == 6'd0) ? S_END : S_PLAY;
                S_PLAY: begin
                    if (beat_ok && cnt_q == 6'd1)
                        state_d = (&idx_q) ? S_END : S_FETCH;
                end
                S_END:   state_d = S_FETCH;
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_comb begin
        song_d    = song_q;
        idx_d     = idx_q;
        note_d    = note_q;
        cnt_d     = cnt_q;
        note_load = 1'b0;
        song_done = 1'b0;
        // next_song squashes the enable one cycle earlier than the plain registered rule would
        pe_d      = (state_q == S_PLAY) && play_i && (note_q != 6'd0) && !next_song_i;
        if (next_song_i) begin
            song_d = song_q + SONG_W'(1);
            idx_d  = '0;
            cnt_d  = '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (rom_dur != 6'd0) begin
                        note_d    = rom_data_i[11:6];
                        cnt_d     = rom_dur;
                        note_load = 1'b1;
                    end
                end
                S_PLAY: begin
                    if (beat_ok && cnt_q != 6'd0) begin
                        cnt_d = cnt_q - 6'd1;
                        if (cnt_q == 6'd1)
                            idx_d = idx_q + NOTE_IDX_W'(1);
                    end
                end
                S_END: begin
                    song_done = 1'b1;
                    idx_d     = '0;
`ifdef SONG_SEQ_LOOP_EN
                    song_d    = song_q;
`else
                    song_d    = song_q + SONG_W'(1);
`endif
                end
                default: ;
            endcase
        end
    end

    assign rom_addr_o     = {song_q, idx_q};
    assign note_to_load_o = note_q;
    assign play_enable_o  = pe_q;
    assign note_load_o    = note_load;
    assign song_done_o    = song_done;
    assign song_o         = song_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: directed vector table, corner-case sequences, random run against a beat-level model.
module tb_song_sequencer;

    logic        clk, rst_n, play, beat, next_song;
    logic [6:0]  rom_addr;
    logic [15:0] rom_data;
    logic [5:0]  note_to_load;
    logic        play_enable, note_load, song_done;
    logic [1:0]  song;

    logic [15:0] rom [0:127];
    int n_chk, n_fail, nl_cnt, sd_cnt;

`ifdef SONG_SEQ_LOOP_EN
    localparam logic [1:0] SONG_AFTER0 = 2'd0;
`else
    localparam logic [1:0] SONG_AFTER0 = 2'd1;
`endif

    song_sequencer dut (
        .clk_i(clk), .rst_n_i(rst_n), .play_i(play), .next_song_i(next_song), .beat_i(beat),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data), .note_to_load_o(note_to_load),
        .play_enable_o(play_enable), .note_load_o(note_load), .song_done_o(song_done), .song_o(song)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    always @(posedge clk) begin
        if (rst_n) begin
            if (note_load) nl_cnt = nl_cnt + 1;
            if (song_done) sd_cnt = sd_cnt + 1;
        end
    end

    typedef struct {
        logic p, b, n, nl, sd, pe;
        logic [5:0] note;
        logic [1:0] s;
        logic [6:0] a;
    } vec_t;
    vec_t tbl [15];

    function automatic vec_t mk(input logic p, b, n, nl, sd, pe, input logic [5:0] note,
                                input logic [1:0] s, input logic [6:0] a);
        vec_t v;
        v.p = p; v.b = b; v.n = n; v.nl = nl; v.sd = sd; v.pe = pe; v.note = note; v.s = s; v.a = a;
        return v;
    endfunction

    function automatic logic [15:0] ent(input logic [5:0] note, input logic [5:0] dur);
        logic [3:0] junk;
        junk = 4'($urandom_range(0, 15));
        return {junk, note, dur};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic pp, input logic bb, input logic nn);
        @(negedge clk);
        play = pp; beat = bb; next_song = nn;
        @(posedge clk);
        #1;
        beat = 1'b0; next_song = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        nl_cnt = 0;
        sd_cnt = 0;
    endtask

    task automatic clear_rom;
        for (int i = 0; i < 128; i++) rom[i] = ent(6'd1, 6'd0);
    endtask

    // beat-level reference: position in the song list, remaining beats, expected pulse counts
    logic [1:0] m_song;
    logic [4:0] m_idx;
    int m_rem, exp_nl, exp_sd;

    task automatic m_adv_song;
`ifndef SONG_SEQ_LOOP_EN
        m_song = m_song + 2'd1;
`endif
    endtask

    task automatic m_settle;
        logic [15:0] e;
        for (int g = 0; g < 300; g++) begin
            e = rom[{m_song, m_idx}];
            if (e[5:0] == 6'd0) begin
                exp_sd++;
                m_adv_song();
                m_idx = 5'd0;
            end else begin
                m_rem = int'(e[5:0]);
                exp_nl++;
                return;
            end
        end
    endtask

    task automatic m_beat;
        m_rem--;
        if (m_rem == 0) begin
            if (m_idx == 5'd31) begin
                m_idx = 5'd0;
                exp_sd++;
                m_adv_song();
            end else begin
                m_idx = m_idx + 5'd1;
            end
            m_settle();
        end
    endtask

    task automatic m_next;
        m_song = m_song + 2'd1;
        m_idx  = 5'd0;
        m_settle();
    endtask

    int nl0, sd0;
    logic p, b, n;
    logic [15:0] e;

    initial begin
        n_chk = 0; n_fail = 0; nl_cnt = 0; sd_cnt = 0;
        play = 1'b0; beat = 1'b0; next_song = 1'b0; rst_n = 1'b0;

        // directed cycle table: song0 = {note10 dur3, rest dur2, end}
        clear_rom();
        rom[7'h00] = ent(6'd10, 6'd3);
        rom[7'h01] = ent(6'd0, 6'd2);
        rom[7'h02] = ent(6'd0, 6'd0);
        rom[7'h20] = ent(6'd5, 6'd2);
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  2'd0, 7'h00);
        tbl[1]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  2'd0, 7'h00);
        tbl[2]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd10, 2'd0, 7'h00);
        tbl[3]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd10, 2'd0, 7'h00);
        tbl[4]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd10, 2'd0, 7'h00);
        tbl[5]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd10, 2'd0, 7'h00);
        tbl[6]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd10, 2'd0, 7'h01);
        tbl[7]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd10, 2'd0, 7'h01);
        tbl[8]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  2'd0, 7'h01);
        tbl[9]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  2'd0, 7'h01);
        tbl[10] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  2'd0, 7'h02);
        tbl[11] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  2'd0, 7'h02);
        tbl[12] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  2'd0, 7'h02);
        tbl[13] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  SONG_AFTER0, {SONG_AFTER0, 5'd0});
        tbl[14] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  SONG_AFTER0, {SONG_AFTER0, 5'd0});

        do_reset();
        chk("reset_pe", 32'(play_enable), 32'd0);
        chk("reset_song", 32'(song), 32'd0);
        chk("reset_addr", 32'(rom_addr), 32'd0);
        chk("reset_note", 32'(note_to_load), 32'd0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            play = tbl[i].p; beat = tbl[i].b; next_song = tbl[i].n;
            #1;
            chk($sformatf("tbl%0d_note_load", i), 32'(note_load), 32'(tbl[i].nl));
            chk($sformatf("tbl%0d_song_done", i), 32'(song_done), 32'(tbl[i].sd));
            chk($sformatf("tbl%0d_play_en", i), 32'(play_enable), 32'(tbl[i].pe));
            chk($sformatf("tbl%0d_note", i), 32'(note_to_load), 32'(tbl[i].note));
            chk($sformatf("tbl%0d_song", i), 32'(song), 32'(tbl[i].s));
            chk($sformatf("tbl%0d_addr", i), 32'(rom_addr), 32'(tbl[i].a));
            @(posedge clk);
            #1;
            beat = 1'b0; next_song = 1'b0;
        end

        // pause: dur-4 note, one beat, five beats while paused, then resume
        clear_rom();
        rom[7'h00] = ent(6'd7, 6'd4);
        rom[7'h01] = ent(6'd8, 6'd1);
        rom[7'h60] = ent(6'd9, 6'd5);
        do_reset();
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("pause_pe_off", 32'(play_enable), 32'd0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
            chk("pause_pe_held", 32'(play_enable), 32'd0);
            chk("pause_addr_held", 32'(rom_addr), 32'h00);
        end
        cyc(1'b1, 1'b0, 1'b0);
        chk("resume_pe", 32'(play_enable), 32'd1);
        repeat (2) cyc(1'b1, 1'b1, 1'b0);
        chk("resume_not_done", 32'(rom_addr), 32'h00);
        cyc(1'b1, 1'b1, 1'b0);
        chk("resume_note_end", 32'(rom_addr), 32'h01);

        // next_song mid-note in song 3 wraps to song 0
        do_reset();
        repeat (3) cyc(1'b1, 1'b0, 1'b1);
        chk("ns_song3", 32'(song), 32'd3);
        chk("ns_addr60", 32'(rom_addr), 32'h60);
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        chk("ns_pe_on", 32'(play_enable), 32'd1);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        chk("ns_wrap_song", 32'(song), 32'd0);
        chk("ns_wrap_addr", 32'(rom_addr), 32'h00);
        chk("ns_pe_off", 32'(play_enable), 32'd0);
        chk("ns_no_done", 32'(sd_cnt), 32'd0);

        // 32 nonzero entries, no end marker
        clear_rom();
        for (int i = 0; i < 32; i++) rom[i] = ent(6'((i % 63) + 1), 6'd1);
        rom[7'h20] = ent(6'd3, 6'd2);
        do_reset();
        for (int i = 0; i < 32; i++) begin
            repeat (2) cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b1, 1'b1, 1'b0);
        end
        cyc(1'b1, 1'b0, 1'b0);
        chk("wrap_loads", 32'(nl_cnt), 32'd32);
        chk("wrap_done", 32'(sd_cnt), 32'd1);
        chk("wrap_song", 32'(song), 32'(SONG_AFTER0));
        chk("wrap_addr", 32'(rom_addr), 32'({SONG_AFTER0, 5'd0}));

        // asynchronous reset in the middle of PLAY
        repeat (4) cyc(1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_note_load", 32'(note_load), 32'd0);
        chk("arst_song_done", 32'(song_done), 32'd0);
        chk("arst_pe", 32'(play_enable), 32'd0);
        chk("arst_note", 32'(note_to_load), 32'd0);
        chk("arst_song", 32'(song), 32'd0);
        chk("arst_addr", 32'(rom_addr), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        nl_cnt = 0; sd_cnt = 0;
        chk("arst_release_addr", 32'(rom_addr), 32'd0);
        repeat (2) cyc(1'b1, 1'b0, 1'b0);
        chk("arst_refetch_load", 32'(nl_cnt), 32'd1);

        // next_song in the same cycle as the final beat of the song
        do_reset();
        for (int i = 0; i < 31; i++) begin
            repeat (2) cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b1, 1'b1, 1'b0);
        end
        repeat (2) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        chk("nsbeat_song", 32'(song), 32'd1);
        chk("nsbeat_addr", 32'(rom_addr), 32'h20);
        cyc(1'b1, 1'b0, 1'b0);
        chk("nsbeat_no_done", 32'(sd_cnt), 32'd0);
        chk("nsbeat_song_hold", 32'(song), 32'd1);

        // random run against the beat-level model; events spaced so every fetch chain settles
        for (int i = 0; i < 128; i++) begin
            if ((i % 32) != 0 && $urandom_range(0, 7) == 0)
                rom[i] = ent(6'($urandom_range(0, 63)), 6'd0);
            else
                rom[i] = ent(($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63)),
                             6'($urandom_range(1, 3)));
        end
        do_reset();
        m_song = 2'd0; m_idx = 5'd0; m_rem = 0; exp_nl = 0; exp_sd = 0;
        m_settle();
        p = 1'b1;
        for (int r = 0; r < 150; r++) begin
            if (r == 0) begin
                b = 1'b0; n = 1'b0;
            end else begin
                int k;
                p = ($urandom_range(0, 4) != 0);
                k = $urandom_range(0, 9);
                b = (k < 7);
                n = (k == 9);
            end
            cyc(p, b, n);
            if (n) m_next();
            else if (b && p) m_beat();
            repeat (8) cyc(p, 1'b0, 1'b0);
            e = rom[{m_song, m_idx}];
            chk("rnd_song", 32'(song), 32'(m_song));
            chk("rnd_addr", 32'(rom_addr), 32'({m_song, m_idx}));
            chk("rnd_note", 32'(note_to_load), 32'(e[11:6]));
            chk("rnd_pe", 32'(play_enable), 32'(p && (e[11:6] != 6'd0)));
            chk("rnd_loads", 32'(nl_cnt), 32'(exp_nl));
            chk("rnd_dones", 32'(sd_cnt), 32'(exp_sd));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
